xadc_temp_poll: RTL and testbench



---
 rtl/xadc_temp_poll.sv | 182 ++++++++++++++++++
 tb/tb_xadc_temp_poll.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xadc_temp_poll.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_temp_poll
//  Description : Periodically reads the XADC on-die temperature register over
//                DRP and presents the 12-bit raw code on device_temp. A WAIT
//                timeout guards against a hung DRP; timeouts are counted in a
//                saturating 8-bit counter.
//                Optional build macro XADC_TEMP_AVG_EN turns device_temp into
//                a 4-sample running mean.
//  Revision    : 1.0 - initial release
// ============================================================================
module xadc_temp_poll #(
    parameter int unsigned POLL_CYCLES    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [6:0]  TEMP_ADDR      = 7'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [11:0] device_temp,
    output logic        temp_valid,
    output logic        sample_seen,
    output logic [7:0]  timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [31:0] c_POLL_RELOAD = 32'(POLL_CYCLES - 1);
    localparam logic [15:0] c_TMO_RELOAD  = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_idle_cnt, w_idle_cnt_nxt;
    logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic        w_sample;
    logic        w_timeout;
    logic        w_den;

    logic [11:0] r_temp;
    logic        r_valid;
    logic        r_seen;
    logic [7:0]  r_tmo_errs;
    logic [11:0] w_raw;
    logic [11:0] w_temp_nxt;
    logic        w_unused_lsb;

    assign w_raw        = drp_do[15:4];
    assign w_unused_lsb = ^drp_do[3:0];

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idle_cnt <= 32'd0;
            r_tmo_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
        end
    end

    // Next-state, counter updates and transaction strobes
    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_sample       = 1'b0;
        w_timeout      = 1'b0;
        w_den          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_idle_cnt == 32'd0) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt - 32'd1;
                end
            end
            S_REQ: begin
                w_den         = 1'b1;
                w_tmo_cnt_nxt = c_TMO_RELOAD;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                // A strobe on the expiry cycle still counts as a good sample
                if (drp_drdy) begin
                    w_sample       = 1'b1;
                    w_idle_cnt_nxt = c_POLL_RELOAD;
                    w_state_nxt    = S_IDLE;
                end else if (r_tmo_cnt == 16'd0) begin
                    w_timeout      = 1'b1;
                    w_idle_cnt_nxt = c_POLL_RELOAD;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef XADC_TEMP_AVG_EN
    logic [11:0] r_hist [4];
    logic [13:0] r_sum;
    logic [1:0]  r_ptr;
    logic [13:0] w_sum_nxt;

    // Running sum: drop the oldest entry, add the new one (mod 2^14 is exact)
    always_comb begin
        w_sum_nxt  = r_sum - {2'b00, r_hist[r_ptr]} + {2'b00, w_raw};
        w_temp_nxt = r_seen ? w_sum_nxt[13:2] : w_raw;
    end

    // History ring; the first sample after reset primes every slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= 12'h000;
            end
            r_sum <= 14'd0;
            r_ptr <= 2'd0;
        end else if (w_sample) begin
            if (!r_seen) begin
                for (int i = 0; i < 4; i++) begin
                    r_hist[i] <= w_raw;
                end
                r_sum <= {w_raw, 2'b00};
                r_ptr <= 2'd0;
            end else begin
                r_hist[r_ptr] <= w_raw;
                r_sum         <= w_sum_nxt;
                r_ptr         <= r_ptr + 2'd1;
            end
        end
    end
`else
    // Raw mode: the latest code is presented unchanged
    always_comb begin
        w_temp_nxt = w_raw;
    end
`endif

    // Output registers: sample capture, valid pulse, sticky flag, error count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_temp     <= 12'h000;
            r_valid    <= 1'b0;
            r_seen     <= 1'b0;
            r_tmo_errs <= 8'd0;
        end else begin
            r_valid <= w_sample;
            if (w_sample) begin
                r_temp <= w_temp_nxt;
                r_seen <= 1'b1;
            end
            if (w_timeout && (r_tmo_errs != 8'hFF)) begin
                r_tmo_errs <= r_tmo_errs + 8'd1;
            end
        end
    end

    assign drp_daddr   = TEMP_ADDR;
    assign drp_den     = w_den;
    assign drp_dwe     = 1'b0;
    assign drp_di      = 16'h0000;
    assign device_temp = r_temp;
    assign temp_valid  = r_valid;
    assign sample_seen = r_seen;
    assign timeout_cnt = r_tmo_errs;

endmodule
`default_nettype wire

// File: tb/tb_xadc_temp_poll.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xadc_temp_poll
//  Description : Randomized bench for xadc_temp_poll. A DRP responder answers
//                each request after a random delay (or never); a
//                transaction-level model predicts request times, captured
//                codes and the timeout count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xadc_temp_poll;

    localparam int         POLL = 16;
    localparam int         TMO  = 8;
    localparam logic [6:0] ADDR = 7'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_drdy = 1'b0;
    logic [11:0] device_temp;
    logic        temp_valid;
    logic        sample_seen;
    logic [7:0]  timeout_cnt;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int vpulses = 0;
    logic prev_den = 1'b0;

    // Reference model state
    int          m_samples = 0;
    int          m_tmo     = 0;
    logic [11:0] m_temp    = 12'h000;
    bit          m_seen    = 1'b0;
    int          exp_den   = 0;
    int unsigned m_hist[$];

    xadc_temp_poll #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO),
        .TEMP_ADDR      (ADDR)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .drp_daddr   (drp_daddr),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .device_temp (device_temp),
        .temp_valid  (temp_valid),
        .sample_seen (sample_seen),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // DRP protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        check("dwe", {31'd0, drp_dwe}, 32'd0);
        check("di", {16'd0, drp_di}, 32'd0);
        check("daddr", {25'd0, drp_daddr}, {25'd0, ADDR});
        check("den_b2b", {31'd0, drp_den & prev_den}, 32'd0);
        check("den_in_rst", {31'd0, drp_den & rst}, 32'd0);
        prev_den = drp_den;
        if (temp_valid) vpulses++;
    end

    task automatic model_reset();
        m_tmo  = 0;
        m_temp = 12'h000;
        m_seen = 1'b0;
        m_hist.delete();
    endtask

    task automatic model_sample(input logic [15:0] d);
        logic [11:0] raw;
        int unsigned sum;
        raw = d[15:4];
        m_samples++;
`ifdef XADC_TEMP_AVG_EN
        if (!m_seen) begin
            m_hist.delete();
            repeat (4) m_hist.push_back(raw);
        end else begin
            m_hist.push_back(raw);
            void'(m_hist.pop_front());
        end
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        m_temp = 12'(sum / 4);
`else
        sum    = 0;
        m_temp = raw + 12'(sum);
`endif
        m_seen = 1'b1;
    endtask

    task automatic wait_den(output int t);
        t = -1;
        for (int i = 0; i < 80; i++) begin
            if (drp_den) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        check("den_seen", {31'd0, (t >= 0)}, 32'd1);
        if (t < 0) finish_sim();
    endtask

    // One DRP transaction: d<0 means no response; otherwise drdy is raised
    // d cycles after the den cycle (0 lands in REQ, >TMO lands in IDLE).
    task automatic run_txn(input int d, input logic [15:0] data);
        int t, tc, last;
        bit taken;
        wait_den(t);
        check("den_time", t, exp_den);
        taken = (d >= 1) && (d <= TMO);
        tc    = t + (taken ? d : TMO) + 1;
        last  = ((d >= 0) && (t + d + 1 > tc)) ? t + d + 1 : tc;
        for (int x = t; x <= last; x++) begin
            if (x == tc) begin
                if (taken) model_sample(data);
                else if (m_tmo < 255) m_tmo++;
                check("temp_valid", {31'd0, temp_valid}, {31'd0, taken});
                check("device_temp", {20'd0, device_temp}, {20'd0, m_temp});
                check("timeout_cnt", {24'd0, timeout_cnt}, m_tmo);
                check("sample_seen", {31'd0, sample_seen}, {31'd0, m_seen});
            end
            drp_drdy = (d >= 0) && (x == t + d);
            drp_do   = drp_drdy ? data : 16'($urandom);
            @(negedge clk);
        end
        drp_drdy = 1'b0;
        exp_den  = tc + POLL;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_den"}, {31'd0, drp_den}, 32'd0);
        check({tag, "_temp"}, {20'd0, device_temp}, 32'd0);
        check({tag, "_valid"}, {31'd0, temp_valid}, 32'd0);
        check({tag, "_seen"}, {31'd0, sample_seen}, 32'd0);
        check({tag, "_tmo"}, {24'd0, timeout_cnt}, 32'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        model_reset();
        exp_den = cyc + 1;

        run_txn(3, 16'hA5C0);
        run_txn(3, 16'h1234);
        run_txn(TMO, 16'h7FF3);
        run_txn(10, 16'h0F0F);
        run_txn(0, 16'hBEEF);
        run_txn(2, 16'h4440);

        repeat (300) run_txn(-1, 16'h0000);

        // Reset mid-WAIT, with a DRP answer arriving while reset is held
        wait_den(t);
        drp_drdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drp_drdy = 1'b1;
        drp_do   = 16'hFFF0;
        @(negedge clk);
        drp_drdy = 1'b0;
        check_zero("mid_rst");
        rst = 1'b0;
        model_reset();
        exp_den = cyc + 1;

        for (int i = 0; i < 1500; i++) begin
            run_txn(int'($urandom_range(0, 12)), 16'($urandom));
        end

        check("valid_pulses", vpulses, m_samples);
        finish_sim();
    end

endmodule
`default_nettype wire
